// File: rtl/alt_vipcts131_common_fifo_stream_ctrl.sv
// Read-side sequencer for a non-showahead FIFO. It waits for a fill threshold, issues
// one line of reads, and re-times the 1-cycle read latency through a 2-entry skid buffer.
module alt_vipcts131_common_fifo_stream_ctrl #(
  parameter int DATA_WIDTH      = 20,
  parameter int DATA_WIDTHU     = 11,
  parameter int LINE_LENGTH     = 1920,
  parameter int START_THRESHOLD = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear_underflow,
  output logic                   fifo_rdreq,
  input  logic [DATA_WIDTH-1:0]  fifo_q,
  input  logic                   fifo_rdempty,
  input  logic [DATA_WIDTHU-1:0] fifo_rdusedw,
  output logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_eol,
  output logic                   line_done,
  output logic                   underflow,
  output logic                   busy
);

  localparam int THRESH = (START_THRESHOLD > LINE_LENGTH) ? LINE_LENGTH : START_THRESHOLD;
  localparam logic [DATA_WIDTHU-1:0] C_THRESH = DATA_WIDTHU'(THRESH);
  localparam logic [DATA_WIDTHU-1:0] C_LEN    = DATA_WIDTHU'(LINE_LENGTH);
  localparam logic [DATA_WIDTHU-1:0] C_LAST   = DATA_WIDTHU'(LINE_LENGTH - 1);
  localparam logic [DATA_WIDTHU-1:0] C_ONE    = DATA_WIDTHU'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTHU-1:0]  r_reads;
  logic                    r_pending;
  logic                    r_pending_eol;
  logic [DATA_WIDTH-1:0]   r_buf0_data;
  logic [DATA_WIDTH-1:0]   r_buf1_data;
  logic                    r_buf0_eol;
  logic                    r_buf1_eol;
  logic [1:0]              r_cnt;
  logic                    r_eol_seen;
  logic                    r_line_done;
  logic                    r_underflow;

  logic                    w_pop;
  logic [2:0]              w_occ;
  logic                    w_room;
  logic                    w_rdreq;
  logic                    w_last_read;
  logic                    w_drain_done;
  logic                    w_enter_fill;
  logic                    w_uf_set;
  logic [1:0]              w_cnt_mid;
  logic [1:0]              w_cnt_nxt;
  logic [DATA_WIDTH-1:0]   w_buf0_data_nxt;
  logic [DATA_WIDTH-1:0]   w_buf1_data_nxt;
  logic                    w_buf0_eol_nxt;
  logic                    w_buf1_eol_nxt;

  // Read issue: only while streaming, and only if the word can land without overfilling the skid buffer
  assign w_pop        = (r_cnt != 2'd0) & dout_ready;
  assign w_occ        = {1'b0, r_cnt} + {2'b00, r_pending};
  assign w_room       = (w_occ - {2'b00, w_pop}) < 3'd2;
  assign w_rdreq      = (r_state == S_STREAM) & ~fifo_rdempty & (r_reads < C_LEN) & w_room;
  assign w_last_read  = w_rdreq & (r_reads == C_LAST);
  assign w_drain_done = (r_cnt == 2'd0) & ~r_pending & r_eol_seen;
  assign w_enter_fill = (w_state_nxt == S_FILL) & (r_state != S_FILL);
  assign w_uf_set     = (r_state == S_STREAM) & (r_cnt == 2'd0) & ~r_pending & dout_ready & fifo_rdempty;

  // Line sequencing; enable is only looked at in IDLE and when a drained line retires
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (fifo_rdusedw >= C_THRESH) begin
          w_state_nxt = S_STREAM;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_STREAM: begin
        if (w_last_read) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_nxt = enable ? S_FILL : S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Skid buffer next state: pop shifts entry 1 to the head, the returning read lands at the new tail
  always_comb begin
    w_buf0_data_nxt = r_buf0_data;
    w_buf1_data_nxt = r_buf1_data;
    w_buf0_eol_nxt  = r_buf0_eol;
    w_buf1_eol_nxt  = r_buf1_eol;
    if (w_pop) begin
      w_buf0_data_nxt = r_buf1_data;
      w_buf0_eol_nxt  = r_buf1_eol;
      w_cnt_mid       = r_cnt - 2'd1;
    end else begin
      w_cnt_mid       = r_cnt;
    end
    if (r_pending) begin
      if (w_cnt_mid == 2'd0) begin
        w_buf0_data_nxt = fifo_q;
        w_buf0_eol_nxt  = r_pending_eol;
      end else begin
        w_buf1_data_nxt = fifo_q;
        w_buf1_eol_nxt  = r_pending_eol;
      end
      w_cnt_nxt = w_cnt_mid + 2'd1;
    end else begin
      w_cnt_nxt = w_cnt_mid;
    end
  end

  // State, read counter and in-flight read tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_reads       <= {DATA_WIDTHU{1'b0}};
      r_pending     <= 1'b0;
      r_pending_eol <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_rdreq;
      r_pending_eol <= w_last_read;
      if (w_enter_fill) begin
        r_reads <= {DATA_WIDTHU{1'b0}};
      end else if (w_rdreq) begin
        r_reads <= r_reads + C_ONE;
      end else begin
        r_reads <= r_reads;
      end
    end
  end

  // Skid buffer storage
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= 2'd0;
      r_buf0_data <= {DATA_WIDTH{1'b0}};
      r_buf1_data <= {DATA_WIDTH{1'b0}};
      r_buf0_eol  <= 1'b0;
      r_buf1_eol  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_buf0_data <= w_buf0_data_nxt;
      r_buf1_data <= w_buf1_data_nxt;
      r_buf0_eol  <= w_buf0_eol_nxt;
      r_buf1_eol  <= w_buf1_eol_nxt;
    end
  end

  // Line completion, line_done pulse and sticky underflow (set wins over clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_eol_seen  <= 1'b0;
      r_line_done <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_line_done <= w_pop & r_buf0_eol;
      if (w_enter_fill) begin
        r_eol_seen <= 1'b0;
      end else if (w_pop & r_buf0_eol) begin
        r_eol_seen <= 1'b1;
      end else begin
        r_eol_seen <= r_eol_seen;
      end
      if (w_uf_set) begin
        r_underflow <= 1'b1;
      end else if (clear_underflow) begin
        r_underflow <= 1'b0;
      end else begin
        r_underflow <= r_underflow;
      end
    end
  end

  assign fifo_rdreq = w_rdreq;
  assign dout_valid = (r_cnt != 2'd0);
  assign dout_data  = (r_cnt != 2'd0) ? r_buf0_data : {DATA_WIDTH{1'b0}};
  assign dout_eol   = (r_cnt != 2'd0) & r_buf0_eol;
  assign line_done  = r_line_done;
  assign underflow  = r_underflow;
  assign busy       = (r_state != S_IDLE);

endmodule
